phy_stim_gen: RTL and testbench

- Synthesizable, parametrised stimulus generator for the PHY transmit path.
- Produces framed traffic: a comma sync preamble, then round-robin per-lane data words, with idle fill between frames.
- Emits a bit-serial stream at bit rate plus a per-word parallel tap, so both serial RX and parallel lane checks can be driven from one source.
- Replaces hand-written bit sequences in benches; can also live on-chip as a BIST source.

---
 rtl/phy_pkg.sv | 32 +++
 rtl/phy_word_src.sv | 57 +++++
 rtl/phy_stim_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_phy_stim_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
`default_nettype none
// =====================================================================
// Package  : phy_pkg
// Purpose  : Shared PHY encodings, default control words and PRBS7 helpers
// Revision : 1.0
// =====================================================================
package phy_pkg;

    localparam logic [1:0] MODE_CNT  = 2'd0;
    localparam logic [1:0] MODE_FIX  = 2'd1;
    localparam logic [1:0] MODE_PRBS = 2'd2;

    localparam logic [7:0] PHY_COMMA = 8'hBC;
    localparam logic [7:0] PHY_IDLE  = 8'h7C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } phy_state_e;

    // x^7 + x^6 + 1, shifting left with the feedback entering at bit 0
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    function automatic logic [6:0] prbs7_seed(input logic [6:0] s);
        return (s == 7'd0) ? 7'h01 : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_word_src.sv
`default_nettype none
// =====================================================================
// Module   : phy_word_src
// Purpose  : Data word generator for counter, fixed and PRBS7 lane data
// Revision : 1.0
// =====================================================================
module phy_word_src
    import phy_pkg::*;
#(
    parameter int DW     = 8,
    parameter int SLOT_W = 3
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [1:0]        mode,
    input  logic [DW-1:0]     seed,
    input  logic [SLOT_W-1:0] slot,
    output logic [DW-1:0]     word
);

    logic [6:0] prbs_q;
    logic [6:0] prbs_d;
    logic [6:0] prbs_next;

    // The word for a slot is the advanced state, so the first slot shows step(seed)
    assign prbs_next = prbs7_step(prbs_q);

    always_comb begin
        prbs_d = prbs_q;
        if (load) begin
            prbs_d = prbs7_seed(seed[6:0]);
        end else if (step) begin
            prbs_d = prbs_next;
        end
    end

    always_comb begin
        case (mode)
            MODE_CNT:  word = seed + DW'(slot);
            MODE_FIX:  word = seed;
            MODE_PRBS: word = DW'(prbs_next);
            default:   word = seed + DW'(slot);
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            prbs_q <= 7'h01;
        end else begin
            prbs_q <= prbs_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/phy_stim_gen.sv
`default_nettype none
// =====================================================================
// Module   : phy_stim_gen
// Purpose  : Framed PHY stimulus: comma sync, round-robin lane data, idle fill
// Revision : 1.0
// =====================================================================
module phy_stim_gen
    import phy_pkg::*;
#(
    parameter int            LANES      = 4,
    parameter int            DW         = 8,
    parameter int            SYNC_WORDS = 4,
    parameter int            FRAME_LEN  = 6,
    parameter logic [DW-1:0] COMMA      = DW'(PHY_COMMA),
    parameter logic [DW-1:0] IDLE       = DW'(PHY_IDLE),
    localparam int           LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [DW-1:0]    seed,
    input  logic [LANES-1:0] lane_en,
    output logic             ser_out,
    output logic [DW-1:0]    word_out,
    output logic [LW-1:0]    word_lane,
    output logic             word_valid,
    output logic             word_stb,
    output logic             busy,
    output logic             done
);

    localparam int BW     = (DW > 1) ? $clog2(DW) : 1;
    localparam int NSLOT  = LANES * FRAME_LEN;
    localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int SYNC_W = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;

    phy_state_e        state_q,      state_d;
    logic [BW-1:0]     bit_cnt_q,    bit_cnt_d;
    logic              start_pend_q, start_pend_d;
    logic [1:0]        mode_q,       mode_d;
    logic [DW-1:0]     seed_q,       seed_d;
    logic [LANES-1:0]  lane_en_q,    lane_en_d;
    logic [SYNC_W-1:0] sync_cnt_q,   sync_cnt_d;
    logic [SLOT_W-1:0] slot_q,       slot_d;
    logic [LW-1:0]     lane_q,       lane_d;
    logic [DW-1:0]     shreg_q,      shreg_d;
    logic              ser_out_q,    ser_out_d;
    logic [DW-1:0]     word_out_q,   word_out_d;
    logic [LW-1:0]     word_lane_q,  word_lane_d;
    logic              word_valid_q, word_valid_d;
    logic              word_stb_q,   word_stb_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;

    logic              boundary;
    logic              sync_last;
    logic              slot_last;
    logic              lane_last;
    logic [SLOT_W-1:0] data_slot;
    logic [LW-1:0]     data_lane;
    logic              data_en;
    logic [DW-1:0]     data_word;
    logic [DW-1:0]     src_word;
    logic [DW-1:0]     next_word;
    logic              src_load;
    logic              src_step;

    assign boundary  = (bit_cnt_q == BW'(DW - 1));
    assign sync_last = (sync_cnt_q == SYNC_W'(SYNC_WORDS - 1));
    assign slot_last = (slot_q == SLOT_W'(NSLOT - 1));
    assign lane_last = (lane_q == LW'(LANES - 1));

    // Slot/lane of the word loaded at the coming boundary (slot 0 when entering DATA)
    assign data_slot = (state_q == ST_DATA) ? slot_q + SLOT_W'(1) : '0;
    assign data_lane = ((state_q == ST_DATA) && !lane_last) ? lane_q + LW'(1) : '0;
    assign data_en   = lane_en_q[data_lane];
    assign data_word = data_en ? src_word : IDLE;

    assign src_load = boundary && (state_q == ST_IDLE) && start_pend_q;
    assign src_step = boundary && (((state_q == ST_SYNC) && sync_last) ||
                                   ((state_q == ST_DATA) && !slot_last));

    phy_word_src #(
        .DW     (DW),
        .SLOT_W (SLOT_W)
    ) u_word_src (
        .clk_32f (clk_32f),
        .reset   (reset),
        .load    (src_load),
        .step    (src_step),
        .mode    (mode_q),
        .seed    (seed_q),
        .slot    (data_slot),
        .word    (src_word)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = boundary ? '0 : bit_cnt_q + BW'(1);
        start_pend_d = start_pend_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        lane_en_d    = lane_en_q;
        sync_cnt_d   = sync_cnt_q;
        slot_d       = slot_q;
        lane_d       = lane_q;
        shreg_d      = {shreg_q[DW-2:0], 1'b0};
        ser_out_d    = shreg_q[DW-1];
        word_out_d   = word_out_q;
        word_lane_d  = word_lane_q;
        word_valid_d = word_valid_q;
        word_stb_d   = boundary;
        busy_d       = busy_q;
        done_d       = 1'b0;
        next_word    = IDLE;

        // The frame's configuration is frozen once the IDLE->SYNC boundary consumes the request
        if ((state_q == ST_IDLE) && start && !src_load) begin
            start_pend_d = 1'b1;
            mode_d       = mode;
            seed_d       = seed;
            lane_en_d    = lane_en;
        end

        if (boundary) begin
            word_lane_d  = '0;
            word_valid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_pend_q) begin
                        state_d      = ST_SYNC;
                        start_pend_d = 1'b0;
                        sync_cnt_d   = '0;
                        busy_d       = 1'b1;
                        next_word    = COMMA;
                    end
                end
                ST_SYNC: begin
                    if (sync_last) begin
                        state_d      = ST_DATA;
                        slot_d       = '0;
                        lane_d       = '0;
                        next_word    = data_word;
                        word_lane_d  = data_lane;
                        word_valid_d = data_en;
                    end else begin
                        sync_cnt_d   = sync_cnt_q + SYNC_W'(1);
                        next_word    = COMMA;
                    end
                end
                ST_DATA: begin
                    if (slot_last) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        slot_d       = data_slot;
                        lane_d       = data_lane;
                        next_word    = data_word;
                        word_lane_d  = data_lane;
                        word_valid_d = data_en;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
            word_out_d = next_word;
            ser_out_d  = next_word[DW-1];
            shreg_d    = {next_word[DW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= BW'(DW - 1);
            start_pend_q <= 1'b0;
            mode_q       <= '0;
            seed_q       <= '0;
            lane_en_q    <= '0;
            sync_cnt_q   <= '0;
            slot_q       <= '0;
            lane_q       <= '0;
            shreg_q      <= '0;
            ser_out_q    <= 1'b0;
            word_out_q   <= '0;
            word_lane_q  <= '0;
            word_valid_q <= 1'b0;
            word_stb_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            start_pend_q <= start_pend_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            lane_en_q    <= lane_en_d;
            sync_cnt_q   <= sync_cnt_d;
            slot_q       <= slot_d;
            lane_q       <= lane_d;
            shreg_q      <= shreg_d;
            ser_out_q    <= ser_out_d;
            word_out_q   <= word_out_d;
            word_lane_q  <= word_lane_d;
            word_valid_q <= word_valid_d;
            word_stb_q   <= word_stb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ser_out    = ser_out_q;
    assign word_out   = word_out_q;
    assign word_lane  = word_lane_q;
    assign word_valid = word_valid_q;
    assign word_stb   = word_stb_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_stim_gen.sv
`default_nettype none
// =====================================================================
// Module   : tb_phy_stim_gen
// Purpose  : Frame vectors checked word-by-word and bit-by-bit via a scoreboard
// Revision : 1.0
// =====================================================================
module tb_phy_stim_gen;

    localparam int         LANES      = 4;
    localparam int         DW         = 8;
    localparam int         SYNC_WORDS = 4;
    localparam int         FRAME_LEN  = 2;
    localparam int         NDATA      = LANES * FRAME_LEN;
    localparam logic [7:0] C_COMMA    = 8'hBC;
    localparam logic [7:0] C_IDLE     = 8'h7C;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic [1:0] mode    = 2'd0;
    logic [7:0] seed    = 8'h00;
    logic [3:0] lane_en = 4'h0;
    logic       ser_out;
    logic [7:0] word_out;
    logic [1:0] word_lane;
    logic       word_valid;
    logic       word_stb;
    logic       busy;
    logic       done;

    initial forever #5 clk_32f = ~clk_32f;

    phy_stim_gen #(
        .LANES      (LANES),
        .DW         (DW),
        .SYNC_WORDS (SYNC_WORDS),
        .FRAME_LEN  (FRAME_LEN),
        .COMMA      (C_COMMA),
        .IDLE       (C_IDLE)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .seed       (seed),
        .lane_en    (lane_en),
        .ser_out    (ser_out),
        .word_out   (word_out),
        .word_lane  (word_lane),
        .word_valid (word_valid),
        .word_stb   (word_stb),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [1:0]      mode;
        logic [7:0]      seed;
        logic [3:0]      lane_en;
        logic [0:7][7:0] words;
        logic [0:7]      valid;
    } vec_t;

    typedef struct packed {
        logic [7:0] word;
        logic [1:0] lane;
        logic       valid;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[6];
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       cur;
    logic       ser_active = 1'b0;
    logic [7:0] ser_acc;
    int         ser_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ser_out"},    32'(ser_out),    0);
        check({tag, "_word_out"},   32'(word_out),   0);
        check({tag, "_word_lane"},  32'(word_lane),  0);
        check({tag, "_word_valid"}, 32'(word_valid), 0);
        check({tag, "_word_stb"},   32'(word_stb),   0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_done"},       32'(done),       0);
    endtask

    // Every word_stb pops one expectation; the following 8 serial bits must rebuild it
    initial begin
        forever begin
            @(negedge clk_32f);
            if (reset) begin
                ser_active = 1'b0;
            end else begin
                if (done && !word_stb) check("done_off_boundary", 32'(done), 0);
                if (word_stb) begin
                    if (ser_active) begin
                        check("serial_len", 32'(ser_n), 8);
                        ser_active = 1'b0;
                    end
                    if (sb.size() > 0) begin
                        cur = sb.pop_front();
                        check("word",  32'(word_out),   32'(cur.word));
                        check("lane",  32'(word_lane),  32'(cur.lane));
                        check("valid", 32'(word_valid), 32'(cur.valid));
                        check("busy",  32'(busy),       32'(cur.busy));
                        check("done",  32'(done),       32'(cur.done));
                        ser_acc    = {7'b0, ser_out};
                        ser_n      = 1;
                        ser_active = 1'b1;
                    end
                end else if (ser_active) begin
                    ser_acc = {ser_acc[6:0], ser_out};
                    ser_n++;
                    if (ser_n == 8) begin
                        check("serial", 32'(ser_acc), 32'(cur.word));
                        ser_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] w, input logic [1:0] l, input logic v,
                        input logic b, input logic d);
        exp_t e;
        e.word  = w;
        e.lane  = l;
        e.valid = v;
        e.busy  = b;
        e.done  = d;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(C_IDLE, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_frame(input vec_t v, input int ndata);
        for (int i = 0; i < SYNC_WORDS; i++) push(C_COMMA, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < ndata; k++) push(v.words[k], 2'(k % LANES), v.valid[k], 1'b1, 1'b0);
        if (ndata == NDATA) push(C_IDLE, 2'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drive_cfg(input vec_t v);
        mode    = v.mode;
        seed    = v.seed;
        lane_en = v.lane_en;
    endtask

    task automatic wait_stb();
        int n = 0;
        do begin
            @(negedge clk_32f);
            n++;
        end while (!word_stb && n < 64);
        if (!word_stb) check("stb_timeout", 32'(word_stb), 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 2000) begin
            @(negedge clk_32f);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic start_frame(input vec_t v);
        wait_stb();
        #1;
        drive_cfg(v);
        start = 1'b1;
        push_frame(v, NDATA);
        @(negedge clk_32f);
        start = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{mode: 2'd0, seed: 8'h10, lane_en: 4'hF,
                    words: {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17}, valid: 8'hFF};
        vecs[1] = '{mode: 2'd0, seed: 8'hFE, lane_en: 4'b0101,
                    words: {8'hFE, 8'h7C, 8'h00, 8'h7C, 8'h02, 8'h7C, 8'h04, 8'h7C}, valid: 8'b10101010};
        vecs[2] = '{mode: 2'd1, seed: 8'hA5, lane_en: 4'hF,
                    words: {8{8'hA5}}, valid: 8'hFF};
        vecs[3] = '{mode: 2'd2, seed: 8'h00, lane_en: 4'hF,
                    words: {8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03, 8'h06}, valid: 8'hFF};
        vecs[4] = '{mode: 2'd3, seed: 8'hFC, lane_en: 4'hF,
                    words: {8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03}, valid: 8'hFF};
        vecs[5] = '{mode: 2'd2, seed: 8'h81, lane_en: 4'b1010,
                    words: {8'h7C, 8'h04, 8'h7C, 8'h10, 8'h7C, 8'h41, 8'h7C, 8'h06}, valid: 8'b01010101};

        // Reset, then idle fill with no start
        reset = 1'b1;
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        check_reset("rst");
        #1;
        push_idle(3);
        reset = 1'b0;
        wait_drain();

        for (int i = 0; i < 6; i++) begin
            start_frame(vecs[i]);
            push_idle(2);
            wait_drain();
        end

        // Reset while data word 3 is on the wire
        wait_stb();
        #1;
        drive_cfg(vecs[0]);
        start = 1'b1;
        push_frame(vecs[0], 4);
        @(negedge clk_32f);
        start = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk_32f);
        reset = 1'b1;
        @(negedge clk_32f);
        check_reset("midrst");
        @(negedge clk_32f);
        #1;
        push_idle(2);
        reset = 1'b0;
        wait_drain();

        // start pulsed again during SYNC must not queue a second frame
        start_frame(vecs[1]);
        wait_stb();
        #1;
        start = 1'b1;
        @(negedge clk_32f);
        start = 1'b0;
        push_idle(3);
        wait_drain();

        // start held through done: next SYNC follows the done word directly
        wait_stb();
        #1;
        drive_cfg(vecs[2]);
        start = 1'b1;
        push_frame(vecs[2], NDATA);
        push_frame(vecs[0], NDATA);
        push_idle(2);
        wait_stb();
        drive_cfg(vecs[0]);
        n = 0;
        do begin
            @(negedge clk_32f);
            n++;
        end while (!done && n < 400);
        if (!done) check("done_timeout", 32'(done), 1);
        @(negedge clk_32f);
        start = 1'b0;
        wait_drain();

        repeat (4) @(negedge clk_32f);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d compared, expected run to end", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
